binary_scan_encoder: RTL

//   Reverse path of the 2-to-4 binary decoder: takes a multi-hot bit vector and emits the binary index of

---
 rtl/binary_scan_encoder.sv | 90 +++++++++
 1 files changed

// File: rtl/binary_scan_encoder.sv
// Multi-hot to binary index scanner: emits the index of every set bit of an
// accepted vector, lowest index first, one code per output handshake.
module binary_scan_encoder #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             zero_det
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state, state_n;
  logic [IN_W-1:0]  pend, pend_n;
  logic             in_ready_n, out_valid_n, out_last_n, zero_det_n;
  logic [OUT_W-1:0] out_code_n;

  // Index of the lowest set bit; 0 for an empty vector.
  function automatic logic [OUT_W-1:0] lowest_idx(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] idx;
    idx = '0;
    for (int i = int'(IN_W) - 1; i >= 0; i--) begin
      if (v[i]) idx = OUT_W'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
      zero_det  <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_code  <= out_code_n;
      out_last  <= out_last_n;
      zero_det  <= zero_det_n;
    end
  end

  // Next state plus the registered-output values that follow from it.
  always_comb begin
    state_n    = state;
    pend_n     = pend;
    zero_det_n = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (in_vec != '0) begin
            pend_n  = in_vec;
            state_n = SCAN;
          end else begin
            zero_det_n = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_valid && out_ready) begin
          // Clearing the lowest set bit retires exactly the code being emitted.
          pend_n = pend & (pend - IN_W'(1));
          if (out_last) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == SCAN);
    out_code_n  = (state_n == SCAN) ? lowest_idx(pend_n) : '0;
    out_last_n  = (state_n == SCAN) && (pend_n != '0) &&
                  ((pend_n & (pend_n - IN_W'(1))) == '0);
  end

endmodule
